// File: rtl/grad_accumulator.sv
// -----------------------------------------------------------------------------
// grad_accumulator
//
// Single-lane gradient reduction stage. After a start pulse it sums a batch of
// signed fixed-point gradient samples with per-add saturation. It then presents
// the finished sum as a one-cycle valid pulse for the downstream update stage.
//
// Ports:
//   clk             rising-edge clock for all state
//   rst             asynchronous reset, active-low (0 = reset asserted)
//   batch_size_in   number of samples in the batch, sampled on an accepted start
//   start_in        one-cycle pulse that begins a new accumulation
//   grad_in         signed gradient sample
//   grad_valid_in   grad_in is valid this cycle
//   grad_out        finished sum while grad_valid_out is high, otherwise 0
//   grad_valid_out  one-cycle pulse marking the finished sum
//   busy_out        high while accumulating or emitting
//   overflow_out    sticky: some add in the current/last batch saturated
// -----------------------------------------------------------------------------
module grad_accumulator #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] batch_size_in,
  input  logic             start_in,
  input  logic [WIDTH-1:0] grad_in,
  input  logic             grad_valid_in,
  output logic [WIDTH-1:0] grad_out,
  output logic             grad_valid_out,
  output logic             busy_out,
  output logic             overflow_out
);

  // FRAC only documents the fixed-point format; the adder does not depend on
  // it. Reject formats that leave no integer bit.
  if (FRAC < 0 || FRAC >= WIDTH) begin : g_bad_frac
    $error("grad_accumulator: FRAC must be in [0, WIDTH-1]");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    EMIT  = 2'd2
  } state_t;

  state_t             state_reg;
  logic [WIDTH-1:0]   acc_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [CNT_W-1:0]   size_reg;
  logic               ovf_reg;
  logic [WIDTH-1:0]   grad_out_reg;
  logic               grad_valid_reg;
  logic               busy_reg;

  logic [WIDTH:0]     sum_wide;
  logic [WIDTH-1:0]   sum_sat;
  logic               sum_clamped;
  logic [CNT_W-1:0]   cnt_next;

  // Add in WIDTH+1 bits. The two top bits differ exactly when the true sum
  // lies outside the WIDTH-bit signed range. The extra sign bit then tells
  // which rail to clamp to.
  always_comb begin
    sum_wide    = {acc_reg[WIDTH-1], acc_reg} + {grad_in[WIDTH-1], grad_in};
    sum_clamped = sum_wide[WIDTH] ^ sum_wide[WIDTH-1];
    sum_sat     = sum_wide[WIDTH-1:0];
    if (sum_clamped) begin
      sum_sat = sum_wide[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}}
                                : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  assign cnt_next = cnt_reg + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      acc_reg        <= '0;
      cnt_reg        <= '0;
      size_reg       <= '0;
      ovf_reg        <= 1'b0;
      grad_out_reg   <= '0;
      grad_valid_reg <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      // The output pulse lasts a single cycle. grad_out returns to zero with it.
      grad_valid_reg <= 1'b0;
      grad_out_reg   <= '0;

      case (state_reg)
        IDLE: begin
          // A zero-length batch would never reach its terminal count, so it
          // is dropped here. overflow_out is left untouched in that case.
          if (start_in && (batch_size_in != '0)) begin
            size_reg  <= batch_size_in;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            ovf_reg   <= 1'b0;
            state_reg <= ACCUM;
            busy_reg  <= 1'b1;
          end
        end

        ACCUM: begin
          if (grad_valid_in) begin
            acc_reg <= sum_sat;
            cnt_reg <= cnt_next;
            if (sum_clamped) begin
              ovf_reg <= 1'b1;
            end
            // The terminal test is an equality check, so the counter never wraps.
            // The result is registered here, so it appears in the EMIT cycle.
            if (cnt_next == size_reg) begin
              state_reg      <= EMIT;
              grad_valid_reg <= 1'b1;
              grad_out_reg   <= sum_sat;
            end
          end
        end

        EMIT: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end

        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign grad_out       = grad_out_reg;
  assign grad_valid_out = grad_valid_reg;
  assign busy_out       = busy_reg;
  assign overflow_out   = ovf_reg;

endmodule

// File: tb/tb_grad_accumulator.sv
// -----------------------------------------------------------------------------
// tb_grad_accumulator
//
// Self-checking bench for grad_accumulator. Table-driven batches push their
// expected sums into a scoreboard queue. A negedge monitor pops the queue on
// each output pulse. Hand-written sequences cover latency, ignored starts,
// zero-length batches and reset in the middle of a batch.
// -----------------------------------------------------------------------------
module tb_grad_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  batch_size_in;
  logic        start_in;
  logic [15:0] grad_in;
  logic        grad_valid_in;
  logic [15:0] grad_out;
  logic        grad_valid_out;
  logic        busy_out;
  logic        overflow_out;

  grad_accumulator #(.WIDTH(16), .FRAC(8), .CNT_W(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .batch_size_in  (batch_size_in),
    .start_in       (start_in),
    .grad_in        (grad_in),
    .grad_valid_in  (grad_valid_in),
    .grad_out       (grad_out),
    .grad_valid_out (grad_valid_out),
    .busy_out       (busy_out),
    .overflow_out   (overflow_out)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [15:0] exp_sum;
    logic        exp_ovf;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  typedef struct packed {
    logic [7:0]       size;
    logic [3:0][15:0] s;
    logic [7:0]       gap;
    logic             mid_start;
    logic             valid_w_start;
    logic [15:0]      exp_sum;
    logic             exp_ovf;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Output monitor: compare every pulse against the scoreboard. Outside
  // pulses, grad_out must read zero.
  always @(negedge clk) begin
    if (rst) begin
      if (grad_valid_out) begin
        if (sb_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_pulse: got grad_out 0x%0h, required no pulse", grad_out);
        end else begin
          mon_e = sb_q.pop_front();
          check("pulse_sum", grad_out, mon_e.exp_sum);
          check("pulse_ovf", overflow_out, mon_e.exp_ovf);
          $display("[TB] pulse grad_out=0x%04h ovf=%0d (expect 0x%04h/%0d)",
                   grad_out, overflow_out, mon_e.exp_sum, mon_e.exp_ovf);
        end
      end else begin
        check("grad_out_zero_when_invalid", grad_out, 16'h0000);
      end
    end
  end

  function automatic vec_t mk(input logic [7:0] size, input logic [15:0] s0,
                              input logic [15:0] s1, input logic [15:0] s2,
                              input logic [15:0] s3, input logic [7:0] gap,
                              input logic mid, input logic vws,
                              input logic [15:0] es, input logic eo);
    vec_t v;
    v.size = size;
    v.s[0] = s0;
    v.s[1] = s1;
    v.s[2] = s2;
    v.s[3] = s3;
    v.gap = gap;
    v.mid_start = mid;
    v.valid_w_start = vws;
    v.exp_sum = es;
    v.exp_ovf = eo;
    return v;
  endfunction

  task automatic run_batch(input vec_t v);
    batch_size_in = v.size;
    start_in      = 1'b1;
    grad_valid_in = v.valid_w_start;
    grad_in       = 16'h7FFF;  // must not be counted even if valid with start
    tick();
    start_in      = 1'b0;
    grad_valid_in = 1'b0;
    check("busy_after_start", busy_out, 1'b1);
    check("ovf_cleared_on_start", overflow_out, 1'b0);
    for (int i = 0; i < int'(v.size); i++) begin
      grad_in       = v.s[i];
      grad_valid_in = 1'b1;
      if (i == int'(v.size) - 1) begin
        sb_q.push_back({v.exp_sum, v.exp_ovf});
      end
      tick();
      grad_valid_in = 1'b0;
      grad_in       = 16'h1234;
      if (i != int'(v.size) - 1) begin
        for (int g = 0; g < int'(v.gap); g++) begin
          if (v.mid_start && g == 0) begin
            start_in      = 1'b1;
            batch_size_in = 8'd1;
          end
          tick();
          start_in = 1'b0;
        end
        check("busy_mid_batch", busy_out, 1'b1);
      end
    end
    // Now in the EMIT cycle; the monitor checks the pulse at negedge.
    check("busy_in_emit", busy_out, 1'b1);
    tick();
    check("busy_back_idle", busy_out, 1'b0);
    check("ovf_sticky_after_batch", overflow_out, v.exp_ovf);
  endtask

  vec_t tbl[7];

  initial begin
    tbl[0] = mk(8'd4, 16'h0100, 16'h0080, 16'hFF80, 16'h0200, 8'd0, 1'b0, 1'b0, 16'h0300, 1'b0);
    tbl[1] = mk(8'd3, 16'h0100, 16'h0100, 16'h0100, 16'h0000, 8'd2, 1'b1, 1'b1, 16'h0300, 1'b0);
    tbl[2] = mk(8'd3, 16'h7000, 16'h2000, 16'hF000, 16'h0000, 8'd0, 1'b0, 1'b0, 16'h6FFF, 1'b1);
    tbl[3] = mk(8'd3, 16'h9000, 16'h9000, 16'h0100, 16'h0000, 8'd1, 1'b0, 1'b0, 16'h8100, 1'b1);
    tbl[4] = mk(8'd2, 16'h8000, 16'hFFFF, 16'h0000, 16'h0000, 8'd0, 1'b0, 1'b0, 16'h8000, 1'b1);
    tbl[5] = mk(8'd2, 16'h7FFF, 16'h0000, 16'h0000, 16'h0000, 8'd0, 1'b0, 1'b0, 16'h7FFF, 1'b0);
    tbl[6] = mk(8'd2, 16'h7FFF, 16'h0001, 16'h0000, 16'h0000, 8'd0, 1'b0, 1'b0, 16'h7FFF, 1'b1);

    rst           = 1'b0;
    batch_size_in = 8'd0;
    start_in      = 1'b0;
    grad_in       = 16'h0000;
    grad_valid_in = 1'b0;
    #1;
    check("reset_grad_out", grad_out, 16'h0000);
    check("reset_valid", grad_valid_out, 1'b0);
    check("reset_busy", busy_out, 1'b0);
    check("reset_ovf", overflow_out, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    tick();

    // Table-driven batches.
    for (int k = 0; k < 7; k++) begin
      $display("[TB] batch %0d size=%0d", k, tbl[k].size);
      run_batch(tbl[k]);
    end

    // Zero-size start is ignored and leaves the sticky overflow alone.
    batch_size_in = 8'd0;
    start_in      = 1'b1;
    tick();
    start_in = 1'b0;
    check("zero_size_busy", busy_out, 1'b0);
    check("zero_size_ovf_unchanged", overflow_out, 1'b1);
    tick();
    check("zero_size_still_idle", busy_out, 1'b0);
    $display("[TB] zero-size start ignored check done");

    // Batch-1 latency, plus a start pulse during EMIT that must be ignored.
    batch_size_in = 8'd1;
    start_in      = 1'b1;
    tick();
    start_in = 1'b0;
    check("lat1_no_pulse_after_start", grad_valid_out, 1'b0);
    check("lat1_busy", busy_out, 1'b1);
    grad_in       = 16'h0040;
    grad_valid_in = 1'b1;
    sb_q.push_back({16'h0040, 1'b0});
    tick();
    grad_valid_in = 1'b0;
    check("lat1_pulse", grad_valid_out, 1'b1);
    check("lat1_value", grad_out, 16'h0040);
    start_in      = 1'b1;
    batch_size_in = 8'd1;
    tick();
    start_in = 1'b0;
    check("lat1_pulse_ends", grad_valid_out, 1'b0);
    check("emit_start_ignored", busy_out, 1'b0);
    tick();
    check("emit_start_still_idle", busy_out, 1'b0);
    $display("[TB] batch-1 latency sequence done");

    // Reset mid-batch: partial sum discarded, no pulse, fresh start accepted.
    batch_size_in = 8'd4;
    start_in      = 1'b1;
    tick();
    start_in = 1'b0;
    for (int i = 0; i < 2; i++) begin
      grad_in       = 16'h7000;
      grad_valid_in = 1'b1;
      tick();
    end
    grad_valid_in = 1'b0;
    rst = 1'b0;
    #1;
    check("midrst_grad_out", grad_out, 16'h0000);
    check("midrst_valid", grad_valid_out, 1'b0);
    check("midrst_busy", busy_out, 1'b0);
    check("midrst_ovf", overflow_out, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("midrst_stays_idle", busy_out, 1'b0);
    $display("[TB] reset mid-batch sequence done");
    run_batch(mk(8'd1, 16'h0040, 16'h0000, 16'h0000, 16'h0000, 8'd0, 1'b0, 1'b0, 16'h0040, 1'b0));

    // Bounded drain of the scoreboard.
    for (int k = 0; k < 20 && sb_q.size() != 0; k++) tick();
    check("scoreboard_drained", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
